// File: rtl/dot_seq_ctrl_if.sv
// Bus between the dot-product sequencer and its neighbours: start/abort control,
// the shared vector-RAM read port, and the published result.
interface dot_seq_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int RES_W  = 16
);
    logic              START;
    logic              ABORT;
    logic              VALID_A;
    logic              VALID_B;
    logic              RD_EN;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] DATA_A;
    logic [DATA_W-1:0] DATA_B;
    logic              WR_LOCK;
    logic              BUSY;
    logic              DONE;
    logic [RES_W-1:0]  RESULT;
    logic              OVF;
    logic              ERR;

    modport slave (
        input  START, ABORT, VALID_A, VALID_B, DATA_A, DATA_B,
        output RD_EN, RD_ADDR, WR_LOCK, BUSY, DONE, RESULT, OVF, ERR
    );

    modport master (
        output START, ABORT, VALID_A, VALID_B, DATA_A, DATA_B,
        input  RD_EN, RD_ADDR, WR_LOCK, BUSY, DONE, RESULT, OVF, ERR
    );
endinterface

// File: rtl/dot_seq_ctrl.sv
// Sequencer for the N-element dot product: walks both vector RAMs, accumulates the
// products and publishes the result. Define DOT_SAT_EN for a saturating RESULT.
module dot_seq_ctrl #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int RES_W  = 16,
    parameter int ACC_W  = 19
) (
    input logic           CLK,
    input logic           RST,
    dot_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ACC_W-1:0]  RES_MAX   = ACC_W'({RES_W{1'b1}});

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                vld_q, vld_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [2*DATA_W-1:0] prod;
    logic                ovf_now;

    assign prod    = (2*DATA_W)'(bus.DATA_A) * (2*DATA_W)'(bus.DATA_B);
    assign ovf_now = (acc_d > RES_MAX);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        acc_d     = acc_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        vld_d     = rd_en_q;

        // RAM data lags RD_EN by one cycle, so the delayed valid gates accumulation.
        if (vld_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    if (bus.VALID_A && bus.VALID_B) begin
                        state_d   = FETCH;
                        acc_d     = '0;
                        rd_addr_d = '0;
                        rd_en_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (bus.ABORT) begin
                    state_d = IDLE;
                    rd_en_d = 1'b0;
                end else if (rd_addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // The last product is in flight on entry; acc_d already includes it.
                state_d = IDLE;
                if (!bus.ABORT) begin
                    done_d = 1'b1;
                    ovf_d  = ovf_now;
`ifdef DOT_SAT_EN
                    result_d = ovf_now ? {RES_W{1'b1}} : acc_d[RES_W-1:0];
`else
                    result_d = acc_d[RES_W-1:0];
`endif
                end
            end
            default: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
            end
        endcase

        // BUSY also covers the DONE cycle so the lock releases only after RESULT is out.
        busy_d = (state_d != IDLE) || done_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            vld_q     <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            vld_q     <= vld_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.RD_EN   = rd_en_q;
    assign bus.RD_ADDR = rd_addr_q;
    assign bus.WR_LOCK = busy_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.RESULT  = result_q;
    assign bus.OVF     = ovf_q;
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Directed bench for dot_seq_ctrl with a synchronous dual-RAM model; honours DOT_SAT_EN
// for the expected saturated result.
module tb_dot_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dot_seq_ctrl_if bus ();
    dot_seq_ctrl dut (.CLK(clk), .RST(rst), .bus(bus));

`ifdef DOT_SAT_EN
    localparam logic [15:0] EXP_ALL255 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_ALL255 = 16'hF008;
`endif

    logic [7:0] mem_a [8];
    logic [7:0] mem_b [8];

    // Synchronous RAM: data appears the cycle after RD_ADDR is sampled.
    always @(posedge clk) begin
        if (bus.RD_EN) begin
            bus.DATA_A <= mem_a[bus.RD_ADDR];
            bus.DATA_B <= mem_b[bus.RD_ADDR];
        end
    end

    int         n_total = 0;
    int         n_bad   = 0;
    int         done_cnt;
    int         done_edge;
    logic       busy_at  [24];
    logic       rd_en_at [24];
    logic [2:0] addr_q   [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; START is sampled on the next rising edge (edge 0).
    // Slot e of the recorded arrays holds the outputs seen after edge e.
    task automatic run_op(input int abort_at, input int repulse_at);
        done_cnt  = 0;
        done_edge = -1;
        addr_q.delete();
        bus.START = 1'b1;
        for (int e = 0; e < 24; e++) begin
            @(negedge clk);
            bus.START   = (e == repulse_at);
            bus.ABORT   = (e == abort_at);
            busy_at[e]  = bus.BUSY;
            rd_en_at[e] = bus.RD_EN;
            if (bus.DONE) begin
                done_cnt++;
                done_edge = e;
            end
            if (bus.RD_EN) addr_q.push_back(bus.RD_ADDR);
        end
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.START   = 1'b0;
        bus.ABORT   = 1'b0;
        bus.VALID_A = 1'b1;
        bus.VALID_B = 1'b1;

        // Reset state
        #2 rst = 1'b1;
        #10;
        check("rst_busy",   32'(bus.BUSY),    32'd0);
        check("rst_rd_en",  32'(bus.RD_EN),   32'd0);
        check("rst_addr",   32'(bus.RD_ADDR), 32'd0);
        check("rst_result", 32'(bus.RESULT),  32'd0);
        check("rst_ovf",    32'(bus.OVF),     32'd0);
        check("rst_done",   32'(bus.DONE),    32'd0);
        check("rst_err",    32'(bus.ERR),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: A=[1..8], B=[8..1] -> 120
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(8 - i);
        end
        run_op(-1, -1);
        check("t1_done_cnt",  32'(done_cnt),    32'd1);
        check("t1_latency",   32'(done_edge),   32'd9);
        check("t1_busy_e0",   32'(busy_at[0]),  32'd1);
        check("t1_wrlock_e0", 32'(busy_at[0]),  32'(bus.WR_LOCK == bus.BUSY));
        check("t1_busy_e9",   32'(busy_at[9]),  32'd1);
        check("t1_busy_e10",  32'(busy_at[10]), 32'd0);
        check("t1_result",    32'(bus.RESULT),  32'd120);
        check("t1_ovf",       32'(bus.OVF),     32'd0);

        // Test 2: all 255 -> overflow
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = 8'd255;
            mem_b[i] = 8'd255;
        end
        run_op(-1, -1);
        check("t2_done_cnt", 32'(done_cnt),   32'd1);
        check("t2_result",   32'(bus.RESULT), 32'(EXP_ALL255));
        check("t2_ovf",      32'(bus.OVF),    32'd1);

        // Restore 120 so the later tests have a known held value
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(8 - i);
        end
        run_op(-1, -1);
        check("t1b_result", 32'(bus.RESULT), 32'd120);
        check("t1b_ovf",    32'(bus.OVF),    32'd0);

        // Test 3: VALID_B low -> ERR pulse only
        bus.VALID_B = 1'b0;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        check("t3_err_hi",  32'(bus.ERR),   32'd1);
        check("t3_busy",    32'(bus.BUSY),  32'd0);
        check("t3_rd_en",   32'(bus.RD_EN), 32'd0);
        @(negedge clk);
        check("t3_err_lo",  32'(bus.ERR),    32'd0);
        check("t3_rd_en2",  32'(bus.RD_EN),  32'd0);
        check("t3_result",  32'(bus.RESULT), 32'd120);
        bus.VALID_B = 1'b1;

        // Test 4: ABORT sampled 4 edges after START
        for (int i = 0; i < 8; i++) mem_a[i] = 8'd9;
        run_op(3, -1);
        check("t4_done_cnt", 32'(done_cnt),    32'd0);
        check("t4_busy_e3",  32'(busy_at[3]),  32'd1);
        check("t4_busy_e4",  32'(busy_at[4]),  32'd0);
        check("t4_rd_en_e4", 32'(rd_en_at[4]), 32'd0);
        check("t4_result",   32'(bus.RESULT),  32'd120);
        check("t4_ovf",      32'(bus.OVF),     32'd0);
        for (int i = 0; i < 8; i++) mem_a[i] = 8'(i + 1);
        run_op(-1, -1);
        check("t4_rerun_done",   32'(done_cnt),   32'd1);
        check("t4_rerun_result", 32'(bus.RESULT), 32'd120);

        // Test 5: RST asserted mid-FETCH
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_addr_pre", 32'(bus.RD_ADDR), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("t5_busy",   32'(bus.BUSY),    32'd0);
        check("t5_rd_en",  32'(bus.RD_EN),   32'd0);
        check("t5_addr",   32'(bus.RD_ADDR), 32'd0);
        check("t5_result", 32'(bus.RESULT),  32'd0);
        check("t5_ovf",    32'(bus.OVF),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 6: START re-pulsed while BUSY is ignored; A=B=[0..7] -> 140
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = 8'(i);
            mem_b[i] = 8'(i);
        end
        run_op(-1, 2);
        check("t6_done_cnt", 32'(done_cnt),       32'd1);
        check("t6_result",   32'(bus.RESULT),     32'd140);
        check("t6_addr_len", 32'(addr_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < addr_q.size()) check($sformatf("t6_addr%0d", i), 32'(addr_q[i]), 32'(i));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
